// File: rtl/pipeline_sequencer.sv
// Multi-stage start/done/ack sequencer with per-stage timeout and pass counting.
// Outputs are registered from the next-state decode so they line up with the state.
module pipeline_sequencer #(
    parameter int N_STAGES = 2,
    parameter int TO_W     = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                single,
    input  logic [N_STAGES-1:0] stage_en,
    input  logic [TO_W-1:0]     timeout_lim,
    input  logic                clr_err,
    input  logic [N_STAGES-1:0] done_in,
    output logic [N_STAGES-1:0] start,
    output logic [N_STAGES-1:0] ack,
    output logic                latch_en,
    output logic                busy,
    output logic [2:0]          cur_stage,
    output logic                err,
    output logic [2:0]          err_stage,
    output logic [15:0]         pass_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        EXEC     = 3'd2,
        DONE     = 3'd3,
        ACK_WAIT = 3'd4,
        LATCH    = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t              state, state_n;
    logic [N_STAGES-1:0] mask, mask_n;
    logic [2:0]          idx, idx_n, err_idx_n;
    logic [TO_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [15:0]         pass_q, pass_n;
    logic [2:0]          first_en, next_en;
    logic                has_next, done_cur, timed_out;
    logic [N_STAGES-1:0] sel_n;

    assign cur_stage = idx;
    assign pass_cnt  = pass_q;

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        first_en = '0;
        next_en  = '0;
        has_next = 1'b0;
        done_cur = 1'b0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (stage_en[i]) first_en = 3'(i);
            if (mask[i] && (i > int'(idx))) begin
                next_en  = 3'(i);
                has_next = 1'b1;
            end
            if (int'(idx) == i) done_cur = done_in[i];
        end
    end

    assign timed_out = (timeout_lim != '0) &&
                       (cnt == timeout_lim - TO_W'(1));
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + TO_W'(1);

    always_comb begin
        state_n   = state;
        mask_n    = mask;
        idx_n     = idx;
        cnt_n     = cnt;
        err_idx_n = err_stage;
        pass_n    = pass_q;
        unique case (state)
            IDLE: begin
                if (run && (stage_en != '0)) begin
                    state_n = START;
                    mask_n  = stage_en;
                    idx_n   = first_en;
                end
            end
            START: begin
                state_n = EXEC;
                cnt_n   = '0;
            end
            EXEC: begin
                if (done_cur) begin
                    state_n = DONE;
                end else if (timed_out) begin
                    state_n   = ERROR;
                    err_idx_n = idx;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            DONE: begin
                state_n = ACK_WAIT;
                cnt_n   = '0;
            end
            ACK_WAIT: begin
                if (!done_cur) begin
                    if (has_next) begin
                        state_n = START;
                        idx_n   = next_en;
                    end else begin
                        state_n = LATCH;
                        pass_n  = pass_q + 16'd1;
                    end
                end else if (timed_out) begin
                    state_n   = ERROR;
                    err_idx_n = idx;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            LATCH: begin
                if (single || !run || (stage_en == '0)) begin
                    state_n = IDLE;
                end else begin
                    state_n = START;
                    mask_n  = stage_en;
                    idx_n   = first_en;
                end
            end
            ERROR: begin
                if (clr_err) state_n = IDLE;
            end
            default: begin
                state_n   = ERROR;
                err_idx_n = 3'd7;
            end
        endcase
    end

    assign sel_n = N_STAGES'(1) << idx_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            mask      <= '0;
            idx       <= '0;
            cnt       <= '0;
            start     <= '0;
            ack       <= '0;
            latch_en  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_stage <= '0;
            pass_q    <= '0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            start     <= ((state_n == START) || (state_n == EXEC)) ? sel_n : '0;
            ack       <= (state_n == ACK_WAIT) ? sel_n : '0;
            latch_en  <= (state_n == LATCH);
            busy      <= (state_n != IDLE) && (state_n != ERROR);
            err       <= (state_n == ERROR);
            err_stage <= err_idx_n;
            pass_q    <= pass_n;
        end
    end

endmodule
